// File: rtl/sc_pkg.sv
// Shared stochastic-computing package.
// Provides the decoder FSM state type and the bipolar mapping used by any
// block that turns a unipolar ones-count into a signed value.
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StAccum
    } sc_dec_state_t;

    // Bipolar value of a window: 2*count - 2^l. Callers size-cast the result
    // to l+2 bits, which always holds the range -2^l..+2^l.
    function automatic int sc_bipolar(input int unsigned count, input int unsigned l);
        return (int'(count) * 2) - (1 << l);
    endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Result port of the stream decoder: valid/ready handshake carrying the
// unsigned ones-count and the bipolar signed value of one window.
//   out_valid  producer -> consumer  result held and not yet consumed
//   out_ready  consumer -> producer  consumer accepts the result
//   count_out  producer -> consumer  ones in window, 0..2^L (L+1 bits)
//   bip_out    producer -> consumer  2*count - 2^L (L+2 bits signed)
interface sc_stream_decoder_if #(
    parameter int unsigned L = 8
) ();

    logic                  out_valid;
    logic                  out_ready;
    logic [L:0]            count_out;
    logic signed [L+1:0]   bip_out;

    modport master (
        output out_valid,
        output count_out,
        output bip_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  count_out,
        input  bip_out,
        output out_ready
    );

endinterface

// File: rtl/sc_window_counter.sv
// Window counter: counts valid samples and ones over a window of 2^L samples.
//   clk, reset  clock / asynchronous active-high reset
//   clear       zero both counters (new measurement)
//   en          a valid sample is being accumulated this cycle
//   din         the sample bit
//   window_end  combinational pulse: this edge consumes the 2^L-th sample
//   ones_final  ones count including the current sample (valid at window_end)
module sc_window_counter #(
    parameter int unsigned L = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic       window_end,
    output logic [L:0] ones_final
);

    logic [L-1:0] samples_q, samples_d;
    logic [L:0]   ones_q, ones_d;

    // Detecting the end at all-ones means the sample counter never wraps.
    assign window_end = en && (samples_q == '1);
    assign ones_final = ones_q + {{L{1'b0}}, din};

    always_comb begin
        samples_d = samples_q;
        ones_d    = ones_q;
        if (clear) begin
            samples_d = '0;
            ones_d    = '0;
        end else if (en) begin
            if (window_end) begin
                samples_d = '0;
                ones_d    = '0;
            end else begin
                samples_d = samples_q + 1'b1;
                ones_d    = ones_final;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samples_q <= '0;
            ones_q    <= '0;
        end else begin
            samples_q <= samples_d;
            ones_q    <= ones_d;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder. After start, discards SKIP valid samples,
// then counts ones over windows of 2^L valid samples and presents each
// result on a valid/ready port.
//   clk, reset  clock / asynchronous active-high reset
//   start       begin a measurement (honoured only when idle)
//   cont        continuous mode, sampled at each window end
//   din_valid   din carries a sample
//   din         stochastic bitstream sample
//   busy        not idle
//   overrun     sticky: a finished window was dropped (cleared on start)
//   res         result port (out_valid/out_ready/count_out/bip_out)
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned L    = 8,
    parameter int unsigned SKIP = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 din_valid,
    input  logic                 din,
    output logic                 busy,
    output logic                 overrun,
    sc_stream_decoder_if.master  res
);

    localparam int unsigned SkipW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP > 0) ? SKIP - 1 : 0);

    sc_dec_state_t state_q, state_d;

    logic [SkipW-1:0]    skip_q, skip_d;
    logic                skip_inc, accum_en, clear;
    logic                window_end;
    logic [L:0]          ones_final;

    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic [L:0]          count_q, count_d;
    logic signed [L+1:0] bip_q, bip_d;
    logic                load, xfer;

    sc_window_counter #(.L(L)) u_window (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .en         (accum_en),
        .din        (din),
        .window_end (window_end),
        .ones_final (ones_final)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (SKIP > 0) ? StSkip : StAccum;
                end
            end
            StSkip: begin
                if (din_valid && (skip_q == SkipLast)) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (window_end && !cont) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q != StIdle);
        clear    = (state_q == StIdle) && start;
        skip_inc = (state_q == StSkip) && din_valid;
        accum_en = (state_q == StAccum) && din_valid;
    end

    // Skip counter: only ever compared against SKIP-1 while in StSkip.
    always_comb begin
        skip_d = skip_q;
        if (clear) begin
            skip_d = '0;
        end else if (skip_inc) begin
            skip_d = skip_q + 1'b1;
        end
    end

    // Result register: a new window may replace a result only if the slot is
    // empty or being drained on this very edge; otherwise it is dropped.
    always_comb begin
        xfer      = valid_q && res.out_ready;
        load      = window_end && (!valid_q || res.out_ready);
        valid_d   = valid_q;
        count_d   = count_q;
        bip_d     = bip_q;
        overrun_d = overrun_q;
        if (clear) begin
            overrun_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            count_d = ones_final;
            bip_d   = (L+2)'(sc_bipolar(32'(ones_final), L));
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
            end
            if (window_end) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            bip_q     <= '0;
        end else begin
            skip_q    <= skip_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            bip_q     <= bip_d;
        end
    end

    assign res.out_valid = valid_q;
    assign res.count_out = count_q;
    assign res.bip_out   = bip_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder (L=4, SKIP=4): directed scenarios followed by
// random traffic, every cycle compared against a sample-index reference model.
module tb_sc_stream_decoder;

    localparam int unsigned L    = 4;
    localparam int unsigned SKIP = 4;
    localparam int          W    = 1 << L;

    logic clk;
    logic reset;
    logic start;
    logic cont;
    logic din_valid;
    logic din;
    logic busy;
    logic overrun;

    sc_stream_decoder_if #(.L(L)) res_if ();

    sc_stream_decoder #(.L(L), .SKIP(SKIP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cont      (cont),
        .din_valid (din_valid),
        .din       (din),
        .busy      (busy),
        .overrun   (overrun),
        .res       (res_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model: n counts valid samples since start; samples 1..SKIP are
    // discarded, then every W samples close a window.
    bit m_active;
    int m_n;
    int m_ones;
    int m_valid;
    int m_count;
    int m_bip;
    int m_ovr;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_n      = 0;
        m_ones   = 0;
        m_valid  = 0;
        m_count  = 0;
        m_bip    = 0;
        m_ovr    = 0;
    endtask

    task automatic model_step();
        bit xfer;
        bit wend;
        int result;
        xfer   = (m_valid != 0) && res_if.out_ready;
        wend   = 1'b0;
        result = 0;
        if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_n      = 0;
                m_ones   = 0;
                m_ovr    = 0;
            end
        end else if (din_valid) begin
            m_n++;
            if (m_n > SKIP) m_ones += int'(din);
            if (m_n == SKIP + W) begin
                wend   = 1'b1;
                result = m_ones;
                m_n    = SKIP;
                m_ones = 0;
                if (!cont) m_active = 1'b0;
            end
        end
        if (wend) begin
            if (m_valid == 0 || xfer) begin
                m_valid = 1;
                m_count = result;
                m_bip   = 2 * result - W;
            end else begin
                m_ovr = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check_val("busy", int'(busy), int'(m_active));
        check_val("out_valid", int'(res_if.out_valid), m_valid);
        check_val("overrun", int'(overrun), m_ovr);
        check_val("count_out", int'(res_if.count_out), m_count);
        check_val("bip_out", int'(res_if.bip_out), m_bip);
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input bit st, input bit cn, input bit dv, input bit d, input bit rdy);
        start            = st;
        cont             = cn;
        din_valid        = dv;
        din              = d;
        res_if.out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        reset            = 1'b1;
        start            = 1'b0;
        cont             = 1'b0;
        din_valid        = 1'b0;
        din              = 1'b0;
        res_if.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // All ones: 4 skipped, then count 16, bipolar +16.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SKIP + W; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("ones_count", int'(res_if.count_out), 16);
        idle(3);

        // Ones only during the skip: count 0, bipolar -16.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SKIP + W; i++) step(1'b0, 1'b0, 1'b1, i < 4, 1'b1);
        check_val("skip_ones_bip", int'(res_if.bip_out), -16);
        idle(2);

        // Alternating: count 8, bipolar 0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SKIP + W; i++) step(1'b0, 1'b0, 1'b1, i[0], 1'b1);
        check_val("alt_count", int'(res_if.count_out), 8);
        idle(2);

        // din_valid every other cycle; invalid-cycle din is random garbage.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * (SKIP + W); i++) begin
            step(1'b0, 1'b0, i[0], i[0] ? 1'b1 : 1'($urandom), 1'b1);
        end
        check_val("sparse_count", int'(res_if.count_out), 16);
        idle(2);

        // Two windows with the consumer stalled: second result dropped.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SKIP + 2 * W; i++) begin
            step(1'b0, i != SKIP + 2 * W - 1, 1'b1, i < SKIP + 3, 1'b0);
        end
        check_val("overrun_set", int'(overrun), 1);
        check_val("held_first", int'(res_if.count_out), 3);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("overrun_clr", int'(overrun), 0);
        for (int i = 0; i < SKIP + W; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Continuous: densities 4/16, 12/16, 16/16 back to back.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SKIP; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < W; i++) begin
                step(1'b0, !(w == 2 && i == W - 1), 1'b1,
                     (w == 0) ? (i < 4) : (w == 1) ? (i < 12) : 1'b1, 1'b1);
            end
        end
        idle(2);

        // Reset mid-window with 5 ones counted, then an all-zero window.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SKIP + 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        pulse_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SKIP + W; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("post_reset_count", int'(res_if.count_out), 0);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) < 7, 1'($urandom),
                     $urandom_range(0, 9) < 6);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary decoder for the receive end of a stochastic-computing datapath. It takes the single serial bitstream produced by a neuron stage, discards a warm-up transient, and counts the ones over a fixed window of 2^L valid samples. It then presents the result as an unsigned ones-count and a bipolar signed value on a valid/ready output port. It sits between a neuron's `dout` and binary readout or host logic.

## Interface
- `L`, default 8: log2 of the window length; window = 2^L valid samples; legal L ≥ 1.
- `SKIP`, default 16: valid samples discarded after `start`, before the first window; 0 is legal.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  **asynchronous, active-high reset; clock `clk`.**
- `start`  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- `cont`  in  1  continuous mode; sampled at each window end.
- `din_valid`  in  1  `din` carries a sample this cycle.
- `din`  in  1  stochastic bitstream sample.
- `busy`  out  1  high in any state other than IDLE.
- `out_valid`  out  1  result registers hold an unconsumed result.
- `out_ready`  in  1  consumer accepts the result.
- `count_out`  out  L+1  ones counted in the window, 0..2^L.
- `bip_out`  out  L+2 signed  2·count − 2^L, range −2^L..+2^L.
- `overrun`  out  1  sticky: a finished window was dropped.

## Operation
- States: IDLE, SKIP, ACCUM.
- **IDLE**
  - `start`=1 → SKIP when SKIP>0, otherwise → ACCUM.
  - Entering from IDLE clears the skip counter, the sample counter, the ones accumulator and `overrun`.
- **SKIP**
  - Each `din_valid` cycle increments the skip counter.
  - Leave for ACCUM on the edge that consumes the SKIP-th valid sample. That sample is discarded.
- **ACCUM**
  - Each `din_valid` cycle: ones += `din`, samples += 1.
  - The edge consuming the 2^L-th valid sample is the window end.
    - The final ones value, including that last sample, goes to the output registers.
    - Both counters clear.
    - `cont`=1 → stay in ACCUM; the next valid sample starts a new window with no skip.
    - `cont`=0 → IDLE.
- **Output load**
  - At a window end, if `out_valid`=0 or (`out_valid` & `out_ready`), load `count_out`/`bip_out` and set `out_valid`.
  - Otherwise drop the new result, keep the old one, and set `overrun`.
- **Handshake**
  - A transfer happens on an edge with `out_valid` & `out_ready`; `out_valid` then falls unless a load happens on the same edge.
  - Output data stays stable while `out_valid`=1 and no transfer has occurred.
  - `out_valid`, `count_out`, `bip_out` and `overrun` are unaffected by entering IDLE. A held result survives until it is consumed.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `din` is ignored when `din_valid`=0 or when in IDLE.
- **Arithmetic**
  - Sample counter is L bits; the window end is detected at all-ones with `din_valid`, so it never wraps.
  - Ones accumulator is L+1 bits and cannot overflow.
  - `bip_out` = {count,0} − 2^L, computed at L+2 bits signed.
- **Reset, asynchronous, any state**
  - State → IDLE; all counters 0; `out_valid`=0, `count_out`=0, `bip_out`=0, `overrun`=0, `busy`=0.
  - A partial window is lost.

## Timing
- `start` high at edge t → `busy`=1 after t; the first sample is consumed at edge t+1.
- With `din_valid` held high, `out_valid` rises after edge t+SKIP+2^L.
- A result is visible the cycle after its window-end edge; one-cycle latency, no combinational path from `din` to outputs.
- `out_ready` may be tied high.
- Back-to-back windows in `cont` mode have zero gap cycles.

## Structure
- Shared package `sc_pkg`:
  - `sc_dec_state_t` enum (IDLE, SKIP, ACCUM).
  - Function `sc_bipolar(count, L)` for the bipolar mapping, reused by binary readout elsewhere.
- One sub-module: `sc_window_counter`, containing the sample counter, ones accumulator and window-end pulse.
- The FSM and output register stay in the top module.

## Test plan
- L=4, SKIP=0, `din`=1 constant, `din_valid`=1 → after 16 samples `count_out`=16, `bip_out`=+16, `out_valid`=1 at cycle 17.
- L=4, SKIP=4:
  - Stream 1,1,1,1 then 16×0 → `count_out`=0, `bip_out`=−16.
  - Alternating 1/0 → `count_out`=8, `bip_out`=0.
- `din_valid` toggling every other cycle, L=3, `din`=1 → result after 8 valid samples (16 cycles), `count_out`=8; invalid-cycle `din` values ignored.
- `cont`=1, `out_ready`=0 across two windows → first result held, `overrun`=1 after second window end.
  - Then `out_ready`=1 → first result transfers.
  - Next `start` in IDLE clears `overrun`.
- `cont`=1, `out_ready`=1 for 3 windows of known densities (4/16, 12/16, 16/16) → three transfers 4, 12, 16 with no gap.
- `reset` pulsed mid-ACCUM with partial count 5 → all outputs 0, IDLE.
  - The following `start` with L=4 all-zero stream → `count_out`=0, not 5.
